pal_cfg_streamer: RTL and testbench

Configuration transmitter for the PAL's serial configuration port. It accepts the PAL bitstream as WORD_W-bit words over a valid/ready handshake and serializes them MSB-first onto the PAL CFG input. It drives the enable that gates the PAL clock, so exactly CFG_BITS configuration bits are clocked in. It sits between the system-side config source (ROM, bus bridge) and the PAL's CLK/CFG pins.

---
 rtl/pal_cfg_pkg.sv | 18 +
 rtl/pal_cfg_crc8.sv | 35 +++
 rtl/pal_cfg_streamer.sv | 152 +++++++++++++++
 tb/tb_pal_cfg_streamer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pal_cfg_pkg.sv
// Shared types and constants for the PAL configuration streamer.
package pal_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Bits in a PAL bitstream: AND-plane (true and complement inputs) plus OR-plane.
  function automatic int cfg_bits(input int n, input int m, input int p);
    return 2 * n * p + p * m;
  endfunction

endpackage

// File: rtl/pal_cfg_crc8.sv
// Bit-serial CRC-8 (MSB-first, init 0x00) over the PAL configuration stream.
// Only compiled when PAL_CFG_CRC_EN is defined; the streamer is its only user.
`ifdef PAL_CFG_CRC_EN
module pal_cfg_crc8
  import pal_cfg_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic       fb;

  assign fb    = crc_q[7] ^ bit_i;
  assign crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  assign crc_o = crc_q;

  // CRC register: clear wins over update, holds when no bit is being sent.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= 8'h00;
    end else if (clr_i) begin
      crc_q <= 8'h00;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

endmodule
`endif

// File: rtl/pal_cfg_streamer.sv
// PAL configuration streamer: accepts WORD_W-bit words over valid/ready and
// shifts exactly CFG_BITS bits MSB-first onto CFG_OUT, gating the PAL clock
// with SHIFT_EN. Optional CRC-8 of the sent stream under PAL_CFG_CRC_EN.
//
// state  | meaning
// IDLE   | waiting for START, all handshake/enable outputs low
// FETCH  | WORD_READY high, waiting for the next word
// SHIFT  | one bit per cycle on CFG_OUT with SHIFT_EN high
// FINISH | single DONE cycle, then back to IDLE
module pal_cfg_streamer
  import pal_cfg_pkg::*;
#(
  parameter int N      = 4,
  parameter int M      = 3,
  parameter int P      = 3,
  parameter int WORD_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [WORD_W-1:0] WORD_DATA,
  input  logic              WORD_VALID,
  output logic              WORD_READY,
  output logic              CFG_OUT,
  output logic              SHIFT_EN,
  output logic              BUSY,
  output logic              DONE
`ifdef PAL_CFG_CRC_EN
  , output logic [7:0]      CRC_OUT
`endif
);

  localparam int CFG_BITS = cfg_bits(N, M, P);
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam int BL_W     = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BL_W-1:0]  BL_ONE   = BL_W'(1);
  localparam logic [BL_W-1:0]  WORD_W_C = BL_W'(WORD_W);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic [BL_W-1:0]   left_q, left_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              word_ready_q, word_ready_d;
  logic              cfg_out_q, cfg_out_d;
  logic              shift_en_q, shift_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  remain;

  // Bits still owed to the PAL; the last word is truncated to this.
  assign remain = LAST_CNT - sent_q;

  // Next-state logic; outputs are decoded from the next state so they register
  // in step with the state they describe.
  always_comb begin
    state_d   = state_q;
    sent_d    = sent_q;
    left_d    = left_q;
    sreg_d    = sreg_q;
    cfg_out_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = FETCH;
          sent_d  = '0;
          left_d  = '0;
        end
      end
      FETCH: begin
        if (WORD_VALID && word_ready_q) begin
          state_d   = SHIFT;
          sreg_d    = WORD_DATA;
          cfg_out_d = WORD_DATA[WORD_W-1];
          left_d    = (32'(remain) < WORD_W) ? BL_W'(remain) : WORD_W_C;
        end
      end
      SHIFT: begin
        sent_d = sent_q + CNT_ONE;
        left_d = left_q - BL_ONE;
        sreg_d = sreg_q << 1;
        if (sent_d == LAST_CNT) begin
          state_d = FINISH;
        end else if (left_q == BL_ONE) begin
          state_d = FETCH;
        end else begin
          cfg_out_d = sreg_d[WORD_W-1];
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    word_ready_d = (state_d == FETCH);
    shift_en_d   = (state_d == SHIFT);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == FINISH);
  end

  // State, datapath and registered outputs; reset drops SHIFT_EN at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      sent_q       <= '0;
      left_q       <= '0;
      sreg_q       <= '0;
      word_ready_q <= 1'b0;
      cfg_out_q    <= 1'b0;
      shift_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sent_q       <= sent_d;
      left_q       <= left_d;
      sreg_q       <= sreg_d;
      word_ready_q <= word_ready_d;
      cfg_out_q    <= cfg_out_d;
      shift_en_q   <= shift_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign WORD_READY = word_ready_q;
  assign CFG_OUT    = cfg_out_q;
  assign SHIFT_EN   = shift_en_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

`ifdef PAL_CFG_CRC_EN
  logic crc_clr;

  // Only an accepted START restarts the CRC; a START mid-load is ignored.
  assign crc_clr = START && (state_q == IDLE);

  pal_cfg_crc8 u_crc8 (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (crc_clr),
    .en_i  (shift_en_q),
    .bit_i (cfg_out_q),
    .crc_o (CRC_OUT)
  );
`endif

endmodule

// File: tb/tb_pal_cfg_streamer.sv
// Scoreboard bench for pal_cfg_streamer at default parameters.
// CRC checks are included when PAL_CFG_CRC_EN is defined.
module tb_pal_cfg_streamer;

  localparam int NBITS = 33;   // 2*4*3 + 3*3

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [7:0] WORD_DATA;
  logic       WORD_VALID;
  logic       WORD_READY;
  logic       CFG_OUT;
  logic       SHIFT_EN;
  logic       BUSY;
  logic       DONE;
`ifdef PAL_CFG_CRC_EN
  logic [7:0] CRC_OUT;
`endif

  pal_cfg_streamer #(.N(4), .M(3), .P(3), .WORD_W(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .WORD_DATA  (WORD_DATA),
    .WORD_VALID (WORD_VALID),
    .WORD_READY (WORD_READY),
    .CFG_OUT    (CFG_OUT),
    .SHIFT_EN   (SHIFT_EN),
    .BUSY       (BUSY),
    .DONE       (DONE)
`ifdef PAL_CFG_CRC_EN
    , .CRC_OUT  (CRC_OUT)
`endif
  );

  always #5 CLK = ~CLK;

  int         total = 0;
  int         bad   = 0;
  bit         exp_q[$];
  int         cyc = 0;
  int         start_cyc = 0;
  int         en_cnt = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         words_done = 0;
  int         ready_late = 0;
  logic [7:0] done_crc = 8'h00;
  logic [7:0] wv[5];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every SHIFT_EN cycle pops one expected bit from the scoreboard.
  always @(negedge CLK) begin
    if (!RST) begin
      if (SHIFT_EN) begin
        en_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_bit: SHIFT_EN=1 at bit %0d with nothing expected", en_cnt);
        end else begin
          bit e;
          e = exp_q.pop_front();
          check($sformatf("cfg_bit%0d", en_cnt), 32'(CFG_OUT), 32'(e));
        end
      end
      if (DONE) begin
        done_cnt++;
        done_cyc = cyc - start_cyc + 1;   // the START cycle counts as cycle 1
`ifdef PAL_CFG_CRC_EN
        done_crc = CRC_OUT;
`endif
      end
      if (words_done >= 5 && WORD_READY) ready_late++;
    end
  end

  task automatic set_words(input logic [7:0] a, b, c, d, e);
    wv[0] = a; wv[1] = b; wv[2] = c; wv[3] = d; wv[4] = e;
  endtask

  task automatic begin_load(input string tag);
    exp_q.delete();
    for (int i = 0; i < NBITS; i++) exp_q.push_back(wv[i / 8][7 - (i % 8)]);
    en_cnt = 0; done_cnt = 0; done_cyc = 0; words_done = 0; ready_late = 0;
    START = 1'b1;
    @(posedge CLK);
    start_cyc = cyc;
    #1 START = 1'b0;
    @(negedge CLK);
    check({tag, "_ready_after_start"}, 32'(WORD_READY), 32'd1);
    check({tag, "_busy_after_start"}, 32'(BUSY), 32'd1);
  endtask

  task automatic send_word(input logic [7:0] w, input int gap, input bit hold);
    int n = 0;
    while (!WORD_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!WORD_READY) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: WORD_READY=0 after %0d cycles, required 1", n);
    end
    WORD_DATA  = w;
    WORD_VALID = (gap == 0);
    repeat (gap) begin
      @(posedge CLK);
      #1;
    end
    WORD_VALID = 1'b1;
    @(posedge CLK);
    #1;
    words_done++;
    WORD_DATA  = 8'h5A;   // junk that must be ignored outside FETCH
    WORD_VALID = hold;
  endtask

  task automatic finish_load(input int exp_cyc, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 300) begin
      @(posedge CLK);
      n++;
    end
    repeat (6) @(posedge CLK);
    #1 WORD_VALID = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_enable_cycles"}, 32'(en_cnt), 32'(NBITS));
    check({tag, "_bits_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_ready_after_last"}, 32'(ready_late), 32'd0);
    check({tag, "_busy_after_done"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; START = 1'b0; WORD_VALID = 1'b0; WORD_DATA = 8'h00;
    #2;
    check("rst_ready", 32'(WORD_READY), 32'd0);
    check("rst_cfg_out", 32'(CFG_OUT), 32'd0);
    check("rst_shift_en", 32'(SHIFT_EN), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
`ifdef PAL_CFG_CRC_EN
    check("rst_crc", 32'(CRC_OUT), 32'd0);
`endif
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;

    // Back-to-back words, WORD_VALID held high with junk between words.
    set_words(8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h80);
    begin_load("t1");
    for (int k = 0; k < 5; k++) send_word(wv[k], 0, 1'b1);
    finish_load(40, "t1");

    // Three-cycle stalls before words 2 and 4.
    begin_load("t2");
    send_word(wv[0], 0, 1'b0);
    send_word(wv[1], 3, 1'b0);
    send_word(wv[2], 0, 1'b0);
    send_word(wv[3], 3, 1'b0);
    send_word(wv[4], 0, 1'b0);
    finish_load(46, "t2");

    // Last word 0xFF: only its top bit is sent.
    set_words(8'hA5, 8'h3C, 8'hFF, 8'h00, 8'hFF);
    begin_load("t3");
    for (int k = 0; k < 5; k++) send_word(wv[k], 0, 1'b1);
    finish_load(40, "t3");

    // START pulsed while shifting word 2 is ignored.
    set_words(8'h96, 8'h69, 8'h0F, 8'hF0, 8'h00);
    begin_load("t4");
    send_word(wv[0], 0, 1'b0);
    send_word(wv[1], 0, 1'b0);
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    for (int k = 2; k < 5; k++) send_word(wv[k], 0, 1'b0);
    finish_load(40, "t4");

    // Asynchronous reset after bit 12, then a clean restart.
    set_words(8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h80);
    begin_load("t5");
    send_word(wv[0], 0, 1'b0);
    send_word(wv[1], 0, 1'b0);
    begin
      int n = 0;
      while (en_cnt < 12 && n < 100) begin
        @(posedge CLK);
        #2;
        n++;
      end
    end
    check("t5_bits_before_rst", 32'(en_cnt), 32'd12);
    RST = 1'b1;
    #1;
    check("t5_rst_shift_en", 32'(SHIFT_EN), 32'd0);
    check("t5_rst_busy", 32'(BUSY), 32'd0);
    check("t5_rst_ready", 32'(WORD_READY), 32'd0);
    check("t5_rst_cfg_out", 32'(CFG_OUT), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;
    begin_load("t6");
    for (int k = 0; k < 5; k++) send_word(wv[k], 0, 1'b0);
    finish_load(40, "t6");

`ifdef PAL_CFG_CRC_EN
    // 32 zeros then a single 1 -> CRC 0x07; all-zero stream -> 0x00.
    set_words(8'h00, 8'h00, 8'h00, 8'h00, 8'h80);
    begin_load("c1");
    for (int k = 0; k < 5; k++) send_word(wv[k], 0, 1'b0);
    finish_load(40, "c1");
    check("c1_crc_at_done", 32'(done_crc), 32'h07);
    check("c1_crc_held", 32'(CRC_OUT), 32'h07);
    set_words(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    begin_load("c2");
    check("c2_crc_cleared", 32'(CRC_OUT), 32'h00);
    for (int k = 0; k < 5; k++) send_word(wv[k], 0, 1'b0);
    finish_load(40, "c2");
    check("c2_crc_at_done", 32'(done_crc), 32'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
